// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Latency: none (types and constants only).
// Backpressure: none.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // s_tick pulses per bit period
    localparam int OVERSAMPLE = 16;
    // s_reg value at the middle of the start bit
    localparam int START_MID  = 7;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pad; resets to the idle-high level.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running).
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset high so a reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start detect, mid-bit LSB-first sampling, stop-bit check.
// Latency: strobe 8 + 16*DBIT + SB_TICK s_ticks after start detection, plus 2 clk sync.
// Backpressure: none; each frame is presented for one cycle and dout/frame_err hold after.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            frame_err
);

    localparam int NW = $clog2(DBIT);

    logic            rx_s;
    state_t          state_reg, state_next;
    logic [4:0]      s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_next;
    logic            ferr_next;
    logic            done_next;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            dout         <= dout_next;
            frame_err    <= ferr_next;
            rx_done_tick <= done_next;
        end
    end

    // Next-state logic; outside IDLE nothing moves unless s_tick is high
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout;
        ferr_next  = frame_err;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                // a tick coincident with detection is deliberately not counted
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == 5'(START_MID)) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // start bit did not survive to mid-bit: treat as a glitch
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 5'(OVERSAMPLE - 1)) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n_reg + 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == 5'(SB_TICK - 1)) begin
                        // bad stop bits are still delivered, flagged via frame_err
                        state_next = IDLE;
                        done_next  = 1'b1;
                        dout_next  = b_reg;
                        ferr_next  = ~rx_s;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: default 8N1 instance plus a 7-bit, 2-stop instance.
// Latency: stimulus-timed; strobe timing checked in s_tick units.
// Backpressure: none.
module tb_uart_rx;

    localparam int M   = 10;       // clk cycles per s_tick
    localparam int BIT = 16 * M;   // clk cycles per nominal bit

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         t0;
        int         ticks;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       s_tick;
    logic       done1, done2;
    logic [7:0] dout1;
    logic [6:0] dout2;
    logic       fe1, fe2;

    int cnt = 0;
    int tick_ctr = 0;
    int vecs = 0;
    int miss = 0;
    int strobes1 = 0;
    int s0;

    exp_t q1[$];
    exp_t q2[$];

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .rx_done_tick (done1),
        .dout         (dout1),
        .frame_err    (fe1)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx2),
        .s_tick       (s_tick),
        .rx_done_tick (done2),
        .dout         (dout2),
        .frame_err    (fe2)
    );

    always #5 clk = ~clk;

    // baud generator stand-in and a free-running tick counter for latency checks
    assign s_tick = (cnt == M - 1);
    always @(posedge clk) begin
        cnt <= (cnt == M - 1) ? 0 : cnt + 1;
        if (s_tick) tick_ctr <= tick_ctr + 1;
    end

    task automatic check(input string name, input int act, input int req);
        vecs++;
        if (act != req) begin
            miss++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input bit sel2, input logic v);
        if (sel2) rx2 = v;
        else      rx  = v;
    endtask

    // one frame, LSB first, starting just after an s_tick; expectation queued at the start edge
    task automatic send(input bit sel2, input logic [7:0] data, input int nbits,
                        input int nstop, input bit stop_low, input int bitc,
                        input logic [7:0] exp_d, input logic exp_fe);
        exp_t e;
        while (cnt != 0) @(negedge clk);
        e.d = exp_d;
        e.fe = exp_fe;
        e.t0 = tick_ctr;
        e.ticks = 152;
        if (sel2) q2.push_back(e);
        else      q1.push_back(e);
        drive(sel2, 1'b0);
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            drive(sel2, data[i]);
            repeat (bitc) @(negedge clk);
        end
        if (stop_low) begin
            // low across the sample point, then back high before the re-armed start check
            drive(sel2, 1'b0);
            repeat (10 * M) @(negedge clk);
            drive(sel2, 1'b1);
            repeat (6 * M) @(negedge clk);
        end else begin
            drive(sel2, 1'b1);
            repeat (nstop * bitc) @(negedge clk);
        end
    endtask

    // monitor for the default instance
    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            strobes1++;
            if (q1.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL unexpected_strobe: dout 0x%0h frame_err %0b, required no strobe", dout1, fe1);
            end else begin
                e = q1.pop_front();
                check("dout", int'(dout1), int'(e.d));
                check("frame_err", int'(fe1), int'(e.fe));
                check("strobe_ticks", tick_ctr - e.t0, e.ticks);
            end
        end
    end

    // monitor for the 7-bit / 2-stop instance
    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            if (q2.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL unexpected_strobe2: dout 0x%0h frame_err %0b, required no strobe", dout2, fe2);
            end else begin
                e = q2.pop_front();
                check("dout2", int'(dout2), int'(e.d));
                check("frame_err2", int'(fe2), int'(e.fe));
                check("strobe_ticks2", tick_ctr - e.t0, e.ticks);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dout", int'(dout1), 0);
        check("rst_frame_err", int'(fe1), 0);
        check("rst_done", int'(done1), 0);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // single 8N1 frame
        send(1'b0, 8'h55, 8, 1, 1'b0, BIT, 8'h55, 1'b0);
        repeat (BIT) @(negedge clk);

        // back-to-back frames with no idle gap
        send(1'b0, 8'hA3, 8, 1, 1'b0, BIT, 8'hA3, 1'b0);
        send(1'b0, 8'h0F, 8, 1, 1'b0, BIT, 8'h0F, 1'b0);
        repeat (BIT) @(negedge clk);

        // short low pulse: rejected at mid start bit
        while (cnt != 0) @(negedge clk);
        s0 = strobes1;
        rx = 1'b0;
        repeat (4 * M) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_dout", int'(dout1), 8'h0F);
        check("glitch_strobes", strobes1, s0);

        // framing error, then a good frame clears it
        send(1'b0, 8'h00, 8, 1, 1'b1, BIT, 8'h00, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        send(1'b0, 8'h7E, 8, 1, 1'b0, BIT, 8'h7E, 1'b0);
        repeat (BIT) @(negedge clk);

        // reset after three data bits of 0xFF
        while (cnt != 0) @(negedge clk);
        s0 = strobes1;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_dout", int'(dout1), 0);
        check("midrst_frame_err", int'(fe1), 0);
        check("midrst_done", int'(done1), 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check("midrst_strobes", strobes1, s0);
        send(1'b0, 8'h81, 8, 1, 1'b0, BIT, 8'h81, 1'b0);
        repeat (BIT) @(negedge clk);

        // 7 data bits, 2 stop bits, transmitter ~3% fast (155 clk per bit instead of 160)
        send(1'b1, 8'h41, 7, 2, 1'b0, 155, 8'h41, 1'b0);
        repeat (2 * BIT) @(negedge clk);

        check("pending_frames", q1.size(), 0);
        check("pending_frames2", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
